// File: rtl/mem_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and data memory.
// slave = arbiter side, master = core/memory environment side.
interface mem_arbiter_if;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_ack;
    logic [31:0] if_rdata;

    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [1:0]  d_nbyte;
    logic        d_unsigned;
    logic        d_ack;
    logic [31:0] d_rdata;

    logic        err;

    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [1:0]  mem_nbyte;
    logic        mem_unsigned;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    modport slave (
        input  if_req, if_addr,
        input  d_req, d_we, d_addr, d_wdata, d_nbyte, d_unsigned,
        input  mem_rvalid, mem_rdata,
        output if_ack, if_rdata, d_ack, d_rdata, err,
        output mem_req, mem_we, mem_addr, mem_wdata, mem_nbyte, mem_unsigned
    );

    modport master (
        output if_req, if_addr,
        output d_req, d_we, d_addr, d_wdata, d_nbyte, d_unsigned,
        output mem_rvalid, mem_rdata,
        input  if_ack, if_rdata, d_ack, d_rdata, err,
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_nbyte, mem_unsigned
    );
endinterface

// File: rtl/mem_arbiter.sv
// Fetch / load-store arbiter for the single data-memory port.
// One transaction in flight, data priority, fetch starvation guard, timeout.
module mem_arbiter #(
    parameter int MAX_STARVE = 3,
    parameter int TIMEOUT    = 16
) (
    input  logic         clk,
    input  logic         rst,
    mem_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    localparam logic [3:0] SC_MAX  = 4'(MAX_STARVE);
    localparam logic [7:0] TC_LAST = 8'(TIMEOUT - 1);

    state_t      r_state, w_state_nxt;
    logic [3:0]  r_starve, w_starve_nxt;
    logic [7:0]  r_tmo, w_tmo_nxt;
    logic        r_owner_d, w_owner_d_nxt;

    logic        r_mem_req, w_mem_req_nxt;
    logic        r_mem_we, w_mem_we_nxt;
    logic [31:0] r_mem_addr, w_mem_addr_nxt;
    logic [31:0] r_mem_wdata, w_mem_wdata_nxt;
    logic [1:0]  r_mem_nbyte, w_mem_nbyte_nxt;
    logic        r_mem_uns, w_mem_uns_nxt;

    logic        r_if_ack, w_if_ack_nxt;
    logic        r_d_ack, w_d_ack_nxt;
    logic        r_err, w_err_nxt;
    logic [31:0] r_if_rdata, w_if_rdata_nxt;
    logic [31:0] r_d_rdata, w_d_rdata_nxt;

    logic        w_starved;
    logic        w_grant_d;
    logic        w_grant_if;

    assign w_starved  = bus.if_req && (r_starve == SC_MAX);
    assign w_grant_d  = bus.d_req && !w_starved;
    assign w_grant_if = bus.if_req && !w_grant_d;

    // Next-state and next-register values; everything holds unless changed.
    always_comb begin
        w_state_nxt     = r_state;
        w_starve_nxt    = r_starve;
        w_tmo_nxt       = r_tmo;
        w_owner_d_nxt   = r_owner_d;
        w_mem_req_nxt   = 1'b0;
        w_mem_we_nxt    = r_mem_we;
        w_mem_addr_nxt  = r_mem_addr;
        w_mem_wdata_nxt = r_mem_wdata;
        w_mem_nbyte_nxt = r_mem_nbyte;
        w_mem_uns_nxt   = r_mem_uns;
        w_if_ack_nxt    = 1'b0;
        w_d_ack_nxt     = 1'b0;
        w_err_nxt       = 1'b0;
        w_if_rdata_nxt  = r_if_rdata;
        w_d_rdata_nxt   = r_d_rdata;

        unique case (r_state)
            S_IDLE: begin
                if (w_grant_d) begin
                    w_owner_d_nxt   = 1'b1;
                    w_mem_we_nxt    = bus.d_we;
                    w_mem_addr_nxt  = bus.d_addr;
                    w_mem_wdata_nxt = bus.d_wdata;
                    w_mem_nbyte_nxt = bus.d_nbyte;
                    w_mem_uns_nxt   = bus.d_unsigned;
                    w_mem_req_nxt   = 1'b1;
                    w_tmo_nxt       = '0;
                    w_state_nxt     = S_WAIT;
                    if (bus.if_req && r_starve != SC_MAX)
                        w_starve_nxt = r_starve + 4'd1;
                end else if (w_grant_if) begin
                    w_owner_d_nxt   = 1'b0;
                    w_mem_we_nxt    = 1'b0;
                    w_mem_addr_nxt  = bus.if_addr;
                    w_mem_nbyte_nxt = 2'b10;
                    w_mem_uns_nxt   = 1'b0;
                    w_mem_req_nxt   = 1'b1;
                    w_tmo_nxt       = '0;
                    w_starve_nxt    = '0;
                    w_state_nxt     = S_WAIT;
                end
            end
            S_WAIT: begin
                if (bus.mem_rvalid) begin
                    if (r_owner_d) begin
                        w_d_rdata_nxt = bus.mem_rdata;
                        w_d_ack_nxt   = 1'b1;
                    end else begin
                        w_if_rdata_nxt = bus.mem_rdata;
                        w_if_ack_nxt   = 1'b1;
                    end
                    w_state_nxt = S_RESP;
                end else if (r_tmo == TC_LAST) begin
                    if (r_owner_d) begin
                        w_d_rdata_nxt = '0;
                        w_d_ack_nxt   = 1'b1;
                    end else begin
                        w_if_rdata_nxt = '0;
                        w_if_ack_nxt   = 1'b1;
                    end
                    w_err_nxt   = 1'b1;
                    w_state_nxt = S_RESP;
                end else begin
                    w_tmo_nxt = r_tmo + 8'd1;
                end
            end
            S_RESP: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State and output registers; reset drops any in-flight response.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_starve    <= '0;
            r_tmo       <= '0;
            r_owner_d   <= 1'b0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_nbyte <= '0;
            r_mem_uns   <= 1'b0;
            r_if_ack    <= 1'b0;
            r_d_ack     <= 1'b0;
            r_err       <= 1'b0;
            r_if_rdata  <= '0;
            r_d_rdata   <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_starve    <= w_starve_nxt;
            r_tmo       <= w_tmo_nxt;
            r_owner_d   <= w_owner_d_nxt;
            r_mem_req   <= w_mem_req_nxt;
            r_mem_we    <= w_mem_we_nxt;
            r_mem_addr  <= w_mem_addr_nxt;
            r_mem_wdata <= w_mem_wdata_nxt;
            r_mem_nbyte <= w_mem_nbyte_nxt;
            r_mem_uns   <= w_mem_uns_nxt;
            r_if_ack    <= w_if_ack_nxt;
            r_d_ack     <= w_d_ack_nxt;
            r_err       <= w_err_nxt;
            r_if_rdata  <= w_if_rdata_nxt;
            r_d_rdata   <= w_d_rdata_nxt;
        end
    end

    assign bus.mem_req      = r_mem_req;
    assign bus.mem_we       = r_mem_we;
    assign bus.mem_addr     = r_mem_addr;
    assign bus.mem_wdata    = r_mem_wdata;
    assign bus.mem_nbyte    = r_mem_nbyte;
    assign bus.mem_unsigned = r_mem_uns;
    assign bus.if_ack       = r_if_ack;
    assign bus.d_ack        = r_d_ack;
    assign bus.err          = r_err;
    assign bus.if_rdata     = r_if_rdata;
    assign bus.d_rdata      = r_d_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: directed plan steps, then random traffic
// checked against a transaction-level model of the arbitration rules.
module tb_mem_arbiter;

    localparam int MAX_STARVE = 3;
    localparam int TIMEOUT    = 16;

    logic clk;
    logic rst;

    mem_arbiter_if bus ();

    mem_arbiter #(
        .MAX_STARVE (MAX_STARVE),
        .TIMEOUT    (TIMEOUT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;

    int m_starve = 0;

    logic [31:0] mem_model [logic [31:0]];

    bit          s_ireq;
    logic [31:0] s_iaddr;
    bit          s_dreq;
    bit          s_we;
    logic [31:0] s_daddr;
    logic [31:0] s_wdata;
    logic [1:0]  s_nb;
    bit          s_un;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: observed no finish, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic req(input bit ir, input logic [31:0] ia,
                       input bit dr, input bit we,
                       input logic [31:0] da, input logic [31:0] wd,
                       input logic [1:0] nb, input bit un);
        s_ireq  = ir; s_iaddr = ia;
        s_dreq  = dr; s_we    = we;
        s_daddr = da; s_wdata = wd;
        s_nb    = nb; s_un    = un;
        bus.if_req     = ir;
        bus.if_addr    = ia;
        bus.d_req      = dr;
        bus.d_we       = we;
        bus.d_addr     = da;
        bus.d_wdata    = wd;
        bus.d_nbyte    = nb;
        bus.d_unsigned = un;
    endtask

    // One full transaction. Called at a negedge in IDLE with requests set.
    // lat: WAIT cycles before mem_rvalid (0 = with mem_req); >= TIMEOUT = never.
    task automatic txn(input int lat, output bit was_d);
        bit          exp_d;
        bit          exp_err;
        int          n;
        int          nw;
        logic [31:0] a;
        logic [31:0] rd;
        logic [31:0] exp_rd;
        exp_d = s_dreq && !(s_ireq && m_starve == MAX_STARVE);
        if (exp_d) begin
            if (s_ireq && m_starve < MAX_STARVE) m_starve++;
        end else begin
            m_starve = 0;
        end
        was_d = exp_d;
        a = exp_d ? s_daddr : s_iaddr;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.mem_req && n < 4);
        chk("grant_latency", n, 1);
        if (bus.mem_req !== 1'b1) return;
        chk("mem_addr", bus.mem_addr, a);
        chk("mem_we", bus.mem_we, exp_d ? s_we : 1'b0);
        chk("mem_nbyte", bus.mem_nbyte, exp_d ? s_nb : 2'b10);
        chk("mem_unsigned", bus.mem_unsigned, exp_d ? s_un : 1'b0);
        if (exp_d && s_we) chk("mem_wdata", bus.mem_wdata, s_wdata);
        nw      = (lat < TIMEOUT) ? lat + 1 : TIMEOUT;
        exp_err = (lat >= TIMEOUT);
        exp_rd  = '0;
        for (int w = 1; w <= nw; w++) begin
            if (w == 2) chk("mem_req_pulse", bus.mem_req, 0);
            chk("no_ack_in_wait", {bus.if_ack, bus.d_ack, bus.err}, 0);
            if (w - 1 == lat) begin
                if (exp_d && s_we) begin
                    rd = $urandom;
                    mem_model[a] = s_wdata;
                end else if (mem_model.exists(a)) begin
                    rd = mem_model[a];
                end else begin
                    rd = $urandom;
                end
                exp_rd = rd;
                bus.mem_rvalid = 1'b1;
                bus.mem_rdata  = rd;
            end
            @(negedge clk);
            bus.mem_rvalid = 1'b0;
            bus.mem_rdata  = $urandom;
        end
        chk("owner_ack", exp_d ? bus.d_ack : bus.if_ack, 1);
        chk("other_ack", exp_d ? bus.if_ack : bus.d_ack, 0);
        chk("err", bus.err, exp_err);
        chk("owner_rdata", exp_d ? bus.d_rdata : bus.if_rdata, exp_rd);
        chk("cmd_stable", bus.mem_addr, a);
        @(negedge clk);
        chk("ack_one_cycle", {bus.if_ack, bus.d_ack, bus.err}, 0);
    endtask

    bit          g;
    bit          ord [8];
    int          r;
    int          lat;
    int          n;
    bit          ir;
    bit          dr;

    initial begin
        ord = '{1, 1, 1, 0, 1, 1, 1, 0};
        rst = 1'b1;
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = '0;
        req(0, '0, 0, 0, '0, '0, 2'b00, 0);
        @(negedge clk);
        @(negedge clk);
        chk("rst_acks", {bus.if_ack, bus.d_ack, bus.err}, 0);
        chk("rst_mem_req", bus.mem_req, 0);
        chk("rst_mem_addr", bus.mem_addr, 0);
        chk("rst_mem_wdata", bus.mem_wdata, 0);
        chk("rst_mem_ctl", {bus.mem_we, bus.mem_nbyte, bus.mem_unsigned}, 0);
        chk("rst_rdata", bus.if_rdata | bus.d_rdata, 0);
        rst = 1'b0;
        @(negedge clk);

        // single fetch
        mem_model[32'h40] = 32'h0010_0093;
        req(1, 32'h40, 0, 0, '0, '0, 2'b00, 0);
        txn(2, g);
        chk("fetch_owner", g, 0);
        chk("fetch_rdata", bus.if_rdata, 32'h0010_0093);
        req(0, '0, 0, 0, '0, '0, 2'b00, 0);
        @(negedge clk);

        // store then load
        req(0, '0, 1, 1, 32'h100, 32'hDEAD_BEEF, 2'b10, 0);
        txn(1, g);
        req(0, '0, 1, 0, 32'h100, '0, 2'b10, 0);
        txn(3, g);
        chk("load_back", bus.d_rdata, 32'hDEAD_BEEF);
        req(0, '0, 0, 0, '0, '0, 2'b00, 0);
        @(negedge clk);

        // contention with both held
        for (int i = 0; i < 8; i++) begin
            req(1, 32'h200 + 4 * i, 1, 0, 32'h300 + 4 * i, '0, 2'b10, 0);
            txn(1, g);
            chk($sformatf("arb_order_%0d", i), g, ord[i]);
        end
        req(0, '0, 0, 0, '0, '0, 2'b00, 0);
        @(negedge clk);

        // timeout, then normal zero-latency load
        req(0, '0, 1, 0, 32'h500, '0, 2'b10, 1);
        txn(1000, g);
        chk("tmo_rdata", bus.d_rdata, 0);
        req(0, '0, 1, 0, 32'h100, '0, 2'b10, 0);
        txn(0, g);
        chk("after_tmo", bus.d_rdata, 32'hDEAD_BEEF);
        req(0, '0, 1, 0, 32'h100, '0, 2'b01, 1);
        txn(TIMEOUT - 1, g);
        req(1, 32'h40, 0, 0, '0, '0, 2'b00, 0);
        txn(TIMEOUT - 1, g);
        chk("terminal_fetch", bus.if_rdata, 32'h0010_0093);
        req(0, '0, 0, 0, '0, '0, 2'b00, 0);
        @(negedge clk);

        // reset in the middle of WAIT
        req(0, '0, 1, 0, 32'h700, '0, 2'b10, 0);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.mem_req && n < 4);
        chk("rst_wait_entry", bus.mem_req, 1);
        #2 rst = 1'b1;
        #1;
        chk("arst_mem_req", bus.mem_req, 0);
        chk("arst_mem_addr", bus.mem_addr, 0);
        chk("arst_acks", {bus.if_ack, bus.d_ack, bus.err}, 0);
        m_starve = 0;
        @(negedge clk);
        req(0, '0, 0, 0, '0, '0, 2'b00, 0);
        rst = 1'b0;
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 32'h1234_5678;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("late_rvalid", {bus.if_ack, bus.d_ack, bus.err, bus.mem_req}, 0);
        end
        bus.mem_rvalid = 1'b0;
        req(0, '0, 1, 0, 32'h100, '0, 2'b10, 0);
        txn(1, g);
        chk("post_rst_load", bus.d_rdata, 32'hDEAD_BEEF);

        // random traffic
        for (int t = 0; t < 60; t++) begin
            ir = 1'($urandom_range(0, 1));
            dr = 1'($urandom_range(0, 1));
            if (!ir && !dr) dr = 1'b1;
            req(ir, 32'h1000 + 4 * $urandom_range(0, 7),
                dr, 1'($urandom_range(0, 1)),
                32'h1000 + 4 * $urandom_range(0, 7), $urandom,
                2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
            r = $urandom_range(0, 9);
            if (r < 7)       lat = $urandom_range(0, 3);
            else if (r == 7) lat = TIMEOUT - 1;
            else if (r == 8) lat = TIMEOUT + 3;
            else             lat = $urandom_range(4, 8);
            txn(lat, g);
        end
        req(0, '0, 0, 0, '0, '0, 2'b00, 0);
        @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single data-memory port between two requesters: the instruction-fetch path and the load/store path.
- Allows one outstanding transaction at a time, sequenced by a 3-state FSM.
- Priority: data beats fetch, with a starvation guard for fetch.
- Includes a response timeout that reports a bus error instead of hanging the core.

Parameters:
- MAX_STARVE, 3: consecutive arbitration losses fetch tolerates before it is forced to win. Legal range 1..15.
- TIMEOUT, 16: WAIT cycles allowed for mem_rvalid before an error response. Legal range 2..255.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- if_req  in  1  fetch request; held with stable if_addr until if_ack.
- if_addr  in  32  fetch address.
- if_ack  out  1  one-cycle pulse: fetch transaction complete, if_rdata valid.
- if_rdata  out  32  fetch read data.
- d_req  in  1  load/store request; payload held stable until d_ack.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  32  data address.
- d_wdata  in  32  store data.
- d_nbyte  in  2  access size code, passed through unchanged.
- d_unsigned  in  1  load zero-extend flag, passed through.
- d_ack  out  1  one-cycle pulse: data transaction complete; d_rdata valid for loads.
- d_rdata  out  32  load data.
- err  out  1  one-cycle pulse alongside if_ack/d_ack when the transaction timed out.
- mem_req  out  1  one-cycle issue pulse to memory.
- mem_we, mem_addr, mem_wdata, mem_nbyte, mem_unsigned  out  1/32/32/2/1  memory command; stable for the whole WAIT state.
- mem_rvalid  in  1  memory completion strobe (reads and writes).
- mem_rdata  in  32  memory read data, valid with mem_rvalid.

Behaviour:
- Reset (asynchronous, active-high; applies mid-transaction too):
  - state = IDLE; starve_cnt = 0; tmo_cnt = 0.
  - All outputs 0, including if_ack, d_ack, err, mem_req and the entire mem_* command.
  - Any in-flight memory response is dropped; no ack is issued for it.
- State IDLE:
  - No request pending: remain in IDLE.
  - Grant selection:
    - Only d_req: grant data.
    - Only if_req: grant fetch.
    - Both requesting: data wins unless starve_cnt == MAX_STARVE, in which case fetch wins.
  - On a grant edge:
    - Latch the granted payload into the mem_* registers (fetch: mem_we = 0, mem_nbyte = 2'b10, mem_unsigned = 0).
    - Record the owner; set mem_req = 1; go to WAIT; set tmo_cnt = 0.
  - starve_cnt update:
    - Increments (saturating at MAX_STARVE) when both request and data wins.
    - Clears whenever fetch is granted.
    - Otherwise unchanged.
- State WAIT:
  - mem_req is 1 only in the first WAIT cycle and 0 afterwards.
  - mem_rvalid is sampled on every WAIT cycle, including the first (zero-latency memory is legal).
  - mem_rvalid = 1: capture mem_rdata into the owner's rdata register; go to RESP.
  - Otherwise tmo_cnt increments. If tmo_cnt reaches TIMEOUT-1 without mem_rvalid: owner rdata = 0, set err flag, go to RESP.
  - mem_rvalid in the same cycle as the timeout terminal count counts as success; err stays 0.
- State RESP (exactly one cycle):
  - Owner's ack = 1; err = 1 only if timed out; the other ack stays 0. Next state is IDLE.
  - Acks are registered outputs.
  - The requester must drop or replace its request on the edge after ack. Arbitration resumes in the following IDLE cycle.
  - Minimum back-to-back period is 3 cycles per transaction (IDLE, WAIT, RESP).
- Rdata registers:
  - if_rdata and d_rdata hold their last value until the next completion for the same owner.
  - A store completion leaves d_rdata = mem_rdata as captured; its value is don't-care to requesters.
- Request handling:
  - Requests are not sampled outside IDLE.
  - A request that drops before it is granted is simply not served.
  - mem_rvalid outside WAIT is ignored.

Test Plan:
- Single fetch: if_req = 1, if_addr = 0x0000_0040, mem_rvalid 2 cycles after mem_req with rdata 0x0010_0093 -> mem_addr = 0x40, mem_we = 0, if_ack pulse with if_rdata = 0x0010_0093, d_ack = 0, err = 0.
- Store then load: d_req store addr 0x100 wdata 0xDEAD_BEEF, then load 0x100, memory echoes -> mem_we = 1 then 0, two d_ack pulses, d_rdata = 0xDEAD_BEEF.
- Contention/starvation: if_req and d_req both held continuously, MAX_STARVE = 3 -> grant order D, D, D, IF, D, D, D, IF; starve_cnt returns to 0 after each IF.
- Timeout: d_req load, mem_rvalid never asserted, TIMEOUT = 16 -> d_ack and err pulse together 17 cycles after the grant edge, d_rdata = 0; next request is served normally with err = 0.
- Zero latency: mem_rvalid asserted in the same cycle as mem_req -> ack exactly 2 cycles after the grant edge; mem_rvalid coinciding with the terminal count -> err = 0.
- Reset mid-WAIT: assert rst asynchronously between edges while in WAIT -> mem_req, mem_addr, acks and err go to 0 immediately; a later mem_rvalid produces no ack.
